hsid_min_dist_sel: RTL and testbench

Minimum-distance selector at the output end of the squared-difference accumulator stream. Consumes the accumulator output beats (valid/value/last/ref), keeps only the final per-reference distances, and tracks the smallest distance and its library reference index across one classification run. Presents the winning reference and distance to the downstream classifier through a valid/ready result handshake.

---
 rtl/hsid_min_dist_sel.sv | 133 +++++++++++++
 tb/tb_hsid_min_dist_sel.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsid_min_dist_sel.sv
// hsid_min_dist_sel
// Tracks the smallest final per-reference distance across one classification
// run and hands the winning reference/distance downstream via valid/ready.
// Partial-sum beats (acc_last=0) are ignored; final beats outside a run only
// raise the sticky overrun flag.

module hsid_min_dist_sel #(
  parameter  int DATA_WIDTH_ACC        = 48,
  parameter  int HSI_LIBRARY_SIZE      = 256,
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] lib_count_m1,
  input  logic                             acc_valid,
  input  logic [DATA_WIDTH_ACC-1:0]        acc_value,
  input  logic                             acc_last,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] acc_ref,
  output logic                             busy,
  output logic                             min_valid,
  input  logic                             min_ready,
  output logic [DATA_WIDTH_ACC-1:0]        min_value,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref,
  output logic                             overrun
);

  localparam int AW = HSI_LIBRARY_SIZE_ADDR;
  localparam int DW = DATA_WIDTH_ACC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt_m1;
  logic [AW-1:0]   r_cnt;
  logic            r_first;
  logic [DW-1:0]   r_min_value;
  logic [AW-1:0]   r_min_ref;
  logic            r_overrun;
  logic            r_busy;
  logic            r_min_valid;

  state_t          w_state_nxt;
  logic [AW-1:0]   w_cnt_m1_nxt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_first_nxt;
  logic [DW-1:0]   w_min_value_nxt;
  logic [AW-1:0]   w_min_ref_nxt;
  logic            w_overrun_nxt;
  logic            w_final;
  logic            w_take;

  assign w_final = acc_valid && acc_last;
  // First final beat of a run loads unconditionally; later ones only on a strict improvement.
  assign w_take  = r_first || (acc_value < r_min_value);

  // Next-state and datapath update; start takes priority over every other event.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_m1_nxt    = r_cnt_m1;
    w_cnt_nxt       = r_cnt;
    w_first_nxt     = r_first;
    w_min_value_nxt = r_min_value;
    w_min_ref_nxt   = r_min_ref;
    w_overrun_nxt   = r_overrun;

    if (start) begin
      w_state_nxt   = S_RUN;
      w_cnt_m1_nxt  = lib_count_m1;
      w_cnt_nxt     = '0;
      w_first_nxt   = 1'b1;
      w_overrun_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_final) w_overrun_nxt = 1'b1;
        end
        S_RUN: begin
          if (w_final) begin
            if (w_take) begin
              w_min_value_nxt = acc_value;
              w_min_ref_nxt   = acc_ref;
            end
            w_first_nxt = 1'b0;
            w_cnt_nxt   = r_cnt + AW'(1);
            if (r_cnt == r_cnt_m1) w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (w_final)   w_overrun_nxt = 1'b1;
          if (min_ready) w_state_nxt   = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; busy/min_valid are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt_m1    <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_min_value <= '0;
      r_min_ref   <= '0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
      r_min_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt_m1    <= w_cnt_m1_nxt;
      r_cnt       <= w_cnt_nxt;
      r_first     <= w_first_nxt;
      r_min_value <= w_min_value_nxt;
      r_min_ref   <= w_min_ref_nxt;
      r_overrun   <= w_overrun_nxt;
      r_busy      <= (w_state_nxt == S_RUN);
      r_min_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign busy      = r_busy;
  assign min_valid = r_min_valid;
  assign min_value = r_min_value;
  assign min_ref   = r_min_ref;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_hsid_min_dist_sel.sv
// Self-checking bench for hsid_min_dist_sel: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a list-based behavioural model.

module tb_hsid_min_dist_sel;

  localparam int DW = 48;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] lib_count_m1;
  logic          acc_valid;
  logic [DW-1:0] acc_value;
  logic          acc_last;
  logic [AW-1:0] acc_ref;
  logic          busy;
  logic          min_valid;
  logic          min_ready;
  logic [DW-1:0] min_value;
  logic [AW-1:0] min_ref;
  logic          overrun;

  hsid_min_dist_sel #(
    .DATA_WIDTH_ACC   (DW),
    .HSI_LIBRARY_SIZE (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .lib_count_m1 (lib_count_m1),
    .acc_valid    (acc_valid),
    .acc_value    (acc_value),
    .acc_last     (acc_last),
    .acc_ref      (acc_ref),
    .busy         (busy),
    .min_valid    (min_valid),
    .min_ready    (min_ready),
    .min_value    (min_value),
    .min_ref      (min_ref),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = collecting finals, 2 = result offered
  int            m_mode;
  int            m_need;
  logic [DW-1:0] m_vals[$];
  logic [AW-1:0] m_refs[$];
  logic [DW-1:0] m_minv;
  logic [AW-1:0] m_minr;
  logic          m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_need = 0; m_vals.delete(); m_refs.delete();
      m_minv = '0; m_minr = '0; m_ovr = 1'b0;
    end else if (start) begin
      m_mode = 1; m_need = int'(lib_count_m1) + 1;
      m_vals.delete(); m_refs.delete(); m_ovr = 1'b0;
    end else begin
      case (m_mode)
        0: if (acc_valid && acc_last) m_ovr = 1'b1;
        1: if (acc_valid && acc_last) begin
             int best;
             m_vals.push_back(acc_value);
             m_refs.push_back(acc_ref);
             best = 0;
             foreach (m_vals[i]) if (m_vals[i] < m_vals[best]) best = i;
             m_minv = m_vals[best];
             m_minr = m_refs[best];
             if (m_vals.size() == m_need) m_mode = 2;
           end
        default: begin
          if (acc_valid && acc_last) m_ovr = 1'b1;
          if (min_ready) m_mode = 0;
        end
      endcase
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("busy",      {63'd0, busy},      {63'd0, (m_mode == 1)});
    check("min_valid", {63'd0, min_valid}, {63'd0, (m_mode == 2)});
    check("overrun",   {63'd0, overrun},   {63'd0, m_ovr});
    check("min_value", {16'd0, min_value}, {16'd0, m_minv});
    check("min_ref",   {56'd0, min_ref},   {56'd0, m_minr});
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [AW-1:0] n_m1);
    start = 1'b1; lib_count_m1 = n_m1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic last, input logic [AW-1:0] r, input logic [DW-1:0] v);
    acc_valid = 1'b1; acc_last = last; acc_ref = r; acc_value = v;
    @(negedge clk);
    acc_valid = 1'b0; acc_last = 1'b0;
  endtask

  task automatic accept();
    min_ready = 1'b1;
    @(negedge clk);
    min_ready = 1'b0;
  endtask

  logic [DW-1:0] all_ones;

  initial begin
    all_ones = '1;
    rst_n = 1'b0; start = 1'b0; lib_count_m1 = '0; acc_valid = 1'b0;
    acc_value = '0; acc_last = 1'b0; acc_ref = '0; min_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_min_value", {16'd0, min_value}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie keeps the earlier reference.
    pulse_start(8'd3);
    check("t1_busy", {63'd0, busy}, 64'd1);
    beat(1'b1, 8'd0, 48'd100);
    beat(1'b1, 8'd1, 48'd40);
    beat(1'b1, 8'd2, 48'd75);
    check("t1_not_done", {63'd0, min_valid}, 64'd0);
    beat(1'b1, 8'd3, 48'd40);
    check("t1_valid", {63'd0, min_valid}, 64'd1);
    check("t1_value", {16'd0, min_value}, 64'd40);
    check("t1_ref",   {56'd0, min_ref},   64'd1);
    accept();
    check("t1_accepted", {63'd0, min_valid}, 64'd0);

    // Partial beats are ignored.
    pulse_start(8'd1);
    beat(1'b1, 8'd0, 48'd500);
    beat(1'b0, 8'd5, 48'd1);
    beat(1'b0, 8'd1, 48'd1);
    beat(1'b1, 8'd1, 48'd20);
    check("t2_value", {16'd0, min_value}, 64'd20);
    check("t2_ref",   {56'd0, min_ref},   64'd1);
    accept();

    // Single-reference run with maximal value, then overrun while held in DONE.
    pulse_start(8'd0);
    beat(1'b1, 8'd7, all_ones);
    check("t3_valid", {63'd0, min_valid}, 64'd1);
    check("t3_value", {16'd0, min_value}, {16'd0, all_ones});
    check("t3_ref",   {56'd0, min_ref},   64'd7);
    repeat (5) @(negedge clk);
    beat(1'b1, 8'd2, 48'd1);
    check("t3_overrun", {63'd0, overrun}, 64'd1);
    check("t3_stable",  {16'd0, min_value}, {16'd0, all_ones});
    accept();
    check("t3_idle", {63'd0, min_valid}, 64'd0);
    pulse_start(8'd0);
    check("t3_ovr_clr", {63'd0, overrun}, 64'd0);
    beat(1'b1, 8'd0, 48'd3);
    accept();

    // Restart mid-run; the final beat coincident with start is discarded.
    pulse_start(8'd3);
    beat(1'b1, 8'd0, 48'd1);
    beat(1'b1, 8'd1, 48'd2);
    start = 1'b1; lib_count_m1 = 8'd3;
    beat(1'b1, 8'd9, 48'd0);
    start = 1'b0;
    beat(1'b1, 8'd0, 48'd9);
    beat(1'b1, 8'd1, 48'd8);
    beat(1'b1, 8'd2, 48'd7);
    beat(1'b1, 8'd3, 48'd6);
    check("t4_valid", {63'd0, min_valid}, 64'd1);
    check("t4_value", {16'd0, min_value}, 64'd6);
    check("t4_ref",   {56'd0, min_ref},   64'd3);
    accept();

    // Asynchronous reset mid-run.
    pulse_start(8'd3);
    beat(1'b1, 8'd2, 48'd5);
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy",      {63'd0, busy},       64'd0);
    check("t5_min_value", {16'd0, min_value},  64'd0);
    check("t5_min_ref",   {56'd0, min_ref},    64'd0);
    check("t5_min_valid", {63'd0, min_valid},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(8'd0);
    beat(1'b1, 8'd4, 48'd33);
    check("t5_value", {16'd0, min_value}, 64'd33);
    check("t5_ref",   {56'd0, min_ref},   64'd4);
    accept();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      start        = ($urandom_range(0, 29) == 0);
      lib_count_m1 = AW'($urandom_range(0, 4));
      acc_valid    = ($urandom_range(0, 9) < 7);
      acc_last     = ($urandom_range(0, 9) < 6);
      acc_ref      = AW'($urandom);
      acc_value    = ($urandom_range(0, 15) == 0) ? {16'($urandom), 32'($urandom)}
                                                  : DW'($urandom_range(0, 15));
      min_ready    = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
